// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU control encodings, R-type
// function codes, multiplier FSM state type and multiply timing.
package ex_stage_pkg;

    // ALUop encodings driven by the decode stage
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    // R-type function codes taken from offsetIn[5:0]
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    // One product bit is resolved per cycle, so a 32-bit multiply takes 32 cycles
    localparam int         MULT_CYCLES  = 32;
    localparam logic [4:0] MUL_LAST_CNT = 5'(MULT_CYCLES - 1);

    // Iterative multiplier states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

    // True when the ALU control selects the iterative multiply
    function automatic logic is_mult_op(input logic [1:0] aluop, input logic [5:0] funct);
        return (aluop == ALUOP_RTYPE) && (funct == FUNCT_MULT);
    endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier. Operands are latched on start; each cycle
// in MUL adds the shifted multiplicand when the current multiplier bit is set.
// The low 32 bits of an unsigned shift-add product equal the low 32 bits of the
// two's-complement signed product, so no sign handling is needed.
// product_o presents the accumulator including the current step, so during the
// final iteration (last_o high) it already holds the complete product.
module seq_multiplier
    import ex_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        last_o,
    output logic [31:0] product_o
);

    mul_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] step_sum_s;

    // Accumulator value after folding in the current multiplier bit
    always_comb begin
        if (mplier_q[0]) begin
            step_sum_s = acc_q + mcand_q;
        end else begin
            step_sum_s = acc_q;
        end
    end

    // Multiplier FSM: latch operands on start, then one product bit per cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        acc_q    <= 32'd0;
                        mcand_q  <= a_i;
                        mplier_q <= b_i;
                        cnt_q    <= 5'd0;
                        state_q  <= ST_MUL;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_q    <= step_sum_s;
                    mcand_q  <= {mcand_q[30:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    if (cnt_q == MUL_LAST_CNT) begin
                        cnt_q   <= 5'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 5'd1;
                        state_q <= ST_MUL;
                    end
                end
                default: begin
                    cnt_q   <= 5'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state_q == ST_MUL);
    assign last_o    = (state_q == ST_MUL) && (cnt_q == MUL_LAST_CNT);
    assign product_o = step_sum_s;

endmodule

// File: rtl/ex_stage.sv
// Pipeline execute stage: operand forwarding, ALU, branch target adder,
// destination select and the EX/MEM pipeline register. Multiplies are handed
// to seq_multiplier and the earlier stages are stalled until it finishes.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    // ID/EX register
    input  logic [1:0]  writeBackIn,
    input  logic [2:0]  memoryIn,
    input  logic [1:0]  ALUop,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic [6:0]  pcIn,
    input  logic [31:0] register1In,
    input  logic [31:0] register2In,
    input  logic [31:0] offsetIn,
    input  logic [4:0]  registerTargetIn,
    input  logic [4:0]  registerDestinationIn,
    // Forwarding sources
    input  logic        memRegWrite,
    input  logic [4:0]  memRd,
    input  logic [31:0] memData,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbRd,
    input  logic [31:0] wbData,
    // EX/MEM register
    output logic [1:0]  writeBackOut,
    output logic [2:0]  memoryOut,
    output logic [31:0] aluResultOut,
    output logic [31:0] writeDataOut,
    output logic [4:0]  registerDestOut,
    output logic        zeroOut,
    output logic [6:0]  branchTargetOut,
    // Hazard control
    output logic        stallOut
);

    logic [4:0]  rs_s;
    logic [5:0]  funct_s;
    logic [31:0] fwd_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_res_s;
    logic [31:0] result_s;
    logic        mult_op_s;
    logic        mul_start_s;
    logic        mul_busy_s;
    logic        mul_last_s;
    logic [31:0] mul_product_s;
    logic        stall_s;

    logic [1:0]  wb_d,     wb_q;
    logic [2:0]  mem_d,    mem_q;
    logic [31:0] alu_d,    alu_q;
    logic [31:0] wdata_d,  wdata_q;
    logic [4:0]  rd_d,     rd_q;
    logic        zero_d,   zero_q;
    logic [6:0]  btgt_d,   btgt_q;

    assign rs_s      = offsetIn[25:21];
    assign funct_s   = offsetIn[5:0];
    assign mult_op_s = is_mult_op(ALUop, funct_s);

    // Operand A forwarding: the younger EX/MEM result wins over MEM/WB; r0 never forwards
    always_comb begin
        if (memRegWrite && (memRd != 5'd0) && (memRd == rs_s)) begin
            fwd_a_s = memData;
        end else if (wbRegWrite && (wbRd != 5'd0) && (wbRd == rs_s)) begin
            fwd_a_s = wbData;
        end else begin
            fwd_a_s = register1In;
        end
    end

    // Operand B forwarding against rt, same priority as operand A
    always_comb begin
        if (memRegWrite && (memRd != 5'd0) && (memRd == registerTargetIn)) begin
            fwd_b_s = memData;
        end else if (wbRegWrite && (wbRd != 5'd0) && (wbRd == registerTargetIn)) begin
            fwd_b_s = wbData;
        end else begin
            fwd_b_s = register2In;
        end
    end

    // ALU B input: immediate for I-type, forwarded register otherwise
    always_comb begin
        if (ALUSrc) begin
            alu_b_s = offsetIn;
        end else begin
            alu_b_s = fwd_b_s;
        end
    end

    // Single-cycle ALU; multiply falls through to add here and takes its result from the multiplier
    always_comb begin
        alu_res_s = fwd_a_s + alu_b_s;
        case (ALUop)
            ALUOP_ADD, ALUOP_ADDI: alu_res_s = fwd_a_s + alu_b_s;
            ALUOP_SUB:             alu_res_s = fwd_a_s - alu_b_s;
            ALUOP_RTYPE: begin
                case (funct_s)
                    FUNCT_ADD: alu_res_s = fwd_a_s + alu_b_s;
                    FUNCT_SUB: alu_res_s = fwd_a_s - alu_b_s;
                    FUNCT_AND: alu_res_s = fwd_a_s & alu_b_s;
                    FUNCT_OR:  alu_res_s = fwd_a_s | alu_b_s;
                    FUNCT_SLT: alu_res_s = ($signed(fwd_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
                    default:   alu_res_s = fwd_a_s + alu_b_s;
                endcase
            end
            default: alu_res_s = fwd_a_s + alu_b_s;
        endcase
    end

    // A multiply is launched only from idle; the held ID/EX keeps it presented until done
    always_comb begin
        if (mult_op_s && !mul_busy_s) begin
            mul_start_s = 1'b1;
        end else begin
            mul_start_s = 1'b0;
        end
    end

    seq_multiplier u_mul (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_i   (mul_start_s),
        .a_i       (fwd_a_s),
        .b_i       (fwd_b_s),
        .busy_o    (mul_busy_s),
        .last_o    (mul_last_s),
        .product_o (mul_product_s)
    );

    // Stall while a multiply is launching or iterating; released on the final iteration
    always_comb begin
        if (!reset_n) begin
            stall_s = 1'b0;
        end else if (mul_busy_s && !mul_last_s) begin
            stall_s = 1'b1;
        end else if (!mul_busy_s && mult_op_s) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Result select: completed product on the multiplier's final cycle, ALU otherwise
    always_comb begin
        if (mul_last_s) begin
            result_s = mul_product_s;
        end else begin
            result_s = alu_res_s;
        end
    end

    // EX/MEM next state; a stalled cycle injects a bubble by clearing the control fields
    always_comb begin
        if (stall_s) begin
            wb_d  = 2'b00;
            mem_d = 3'b000;
        end else begin
            wb_d  = writeBackIn;
            mem_d = memoryIn;
        end
        alu_d   = result_s;
        zero_d  = (result_s == 32'd0);
        wdata_d = fwd_b_s;
        btgt_d  = pcIn + offsetIn[6:0];
        if (RegDst) begin
            rd_d = registerDestinationIn;
        end else begin
            rd_d = registerTargetIn;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_q    <= 2'b00;
            mem_q   <= 3'b000;
            alu_q   <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            zero_q  <= 1'b0;
            btgt_q  <= 7'd0;
        end else begin
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            zero_q  <= zero_d;
            btgt_q  <= btgt_d;
        end
    end

    assign writeBackOut    = wb_q;
    assign memoryOut       = mem_q;
    assign aluResultOut    = alu_q;
    assign writeDataOut    = wdata_q;
    assign registerDestOut = rd_q;
    assign zeroOut         = zero_q;
    assign branchTargetOut = btgt_q;
    assign stallOut        = stall_s;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by randomized
// instructions, all compared against a behavioural model of the stage.
module tb_ex_stage;

    logic        clock;
    logic        reset_n;
    logic [1:0]  writeBackIn;
    logic [2:0]  memoryIn;
    logic [1:0]  ALUop;
    logic        ALUSrc;
    logic        RegDst;
    logic [6:0]  pcIn;
    logic [31:0] register1In;
    logic [31:0] register2In;
    logic [31:0] offsetIn;
    logic [4:0]  registerTargetIn;
    logic [4:0]  registerDestinationIn;
    logic        memRegWrite;
    logic [4:0]  memRd;
    logic [31:0] memData;
    logic        wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic [1:0]  writeBackOut;
    logic [2:0]  memoryOut;
    logic [31:0] aluResultOut;
    logic [31:0] writeDataOut;
    logic [4:0]  registerDestOut;
    logic        zeroOut;
    logic [6:0]  branchTargetOut;
    logic        stallOut;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage dut (
        .clock(clock), .reset_n(reset_n),
        .writeBackIn(writeBackIn), .memoryIn(memoryIn), .ALUop(ALUop),
        .ALUSrc(ALUSrc), .RegDst(RegDst), .pcIn(pcIn),
        .register1In(register1In), .register2In(register2In), .offsetIn(offsetIn),
        .registerTargetIn(registerTargetIn), .registerDestinationIn(registerDestinationIn),
        .memRegWrite(memRegWrite), .memRd(memRd), .memData(memData),
        .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
        .writeBackOut(writeBackOut), .memoryOut(memoryOut), .aluResultOut(aluResultOut),
        .writeDataOut(writeDataOut), .registerDestOut(registerDestOut), .zeroOut(zeroOut),
        .branchTargetOut(branchTargetOut), .stallOut(stallOut)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Forwarding rule: newest writer of a non-zero register wins, else the register file value
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (memRegWrite && memRd != 5'd0 && memRd == r) return memData;
        if (wbRegWrite && wbRd != 5'd0 && wbRd == r) return wbData;
        return rf;
    endfunction

    function automatic logic is_mul();
        return (ALUop == 2'b10) && (offsetIn[5:0] == 6'h18);
    endfunction

    // Reference arithmetic straight from the operation table
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [31:0] bsel);
        int sa, sb;
        sa = a;
        sb = bsel;
        if (ALUop == 2'b01) return a - bsel;
        if (ALUop != 2'b10) return a + bsel;
        case (offsetIn[5:0])
            6'h22:   return a - bsel;
            6'h24:   return a & bsel;
            6'h25:   return a | bsel;
            6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
            6'h18: begin
                sa = a;
                sb = b;
                return sa * sb;
            end
            default: return a + bsel;
        endcase
    endfunction

    // Executes the currently driven instruction and checks the EX/MEM result
    task automatic exec(input string tag);
        logic [31:0] a, b, res, wd_exp;
        logic [6:0]  bt_exp;
        logic [4:0]  rd_exp;
        int stalls, bad_bubbles;
        a   = fwd(offsetIn[25:21], register1In);
        b   = fwd(registerTargetIn, register2In);
        res = ref_result(a, b, ALUSrc ? offsetIn : b);
        #1;
        if (is_mul()) begin
            stalls = 0;
            bad_bubbles = 0;
            for (int k = 0; k < 40 && stallOut === 1'b1; k++) begin
                stalls++;
                @(posedge clock);
                #1;
                if (writeBackOut !== 2'b00 || memoryOut !== 3'b000) bad_bubbles++;
            end
            check({tag, ".stall_cycles"}, stalls, 32);
            check({tag, ".bubbles"}, bad_bubbles, 0);
        end else begin
            check({tag, ".nostall"}, {31'd0, stallOut}, 32'd0);
        end
        wd_exp = fwd(registerTargetIn, register2In);
        bt_exp = pcIn + offsetIn[6:0];
        rd_exp = RegDst ? registerDestinationIn : registerTargetIn;
        @(posedge clock);
        #1;
        check({tag, ".alu"},   aluResultOut, res);
        check({tag, ".zero"},  {31'd0, zeroOut}, {31'd0, (res == 32'd0)});
        check({tag, ".wdata"}, writeDataOut, wd_exp);
        check({tag, ".btgt"},  {25'd0, branchTargetOut}, {25'd0, bt_exp});
        check({tag, ".rd"},    {27'd0, registerDestOut}, {27'd0, rd_exp});
        check({tag, ".ctl"},   {27'd0, writeBackOut, memoryOut}, {27'd0, writeBackIn, memoryIn});
    endtask

    task automatic clear_inputs();
        writeBackIn = 2'b01; memoryIn = 3'b010; ALUop = 2'b00; ALUSrc = 1'b0; RegDst = 1'b0;
        pcIn = 7'd0; register1In = 32'd0; register2In = 32'd0; offsetIn = 32'd0;
        registerTargetIn = 5'd0; registerDestinationIn = 5'd0;
        memRegWrite = 1'b0; memRd = 5'd0; memData = 32'd0;
        wbRegWrite = 1'b0; wbRd = 5'd0; wbData = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb"},    {30'd0, writeBackOut}, 32'd0);
        check({tag, ".mem"},   {29'd0, memoryOut}, 32'd0);
        check({tag, ".alu"},   aluResultOut, 32'd0);
        check({tag, ".wdata"}, writeDataOut, 32'd0);
        check({tag, ".rd"},    {27'd0, registerDestOut}, 32'd0);
        check({tag, ".zero"},  {31'd0, zeroOut}, 32'd0);
        check({tag, ".btgt"},  {25'd0, branchTargetOut}, 32'd0);
        check({tag, ".stall"}, {31'd0, stallOut}, 32'd0);
    endtask

    initial begin
        logic [5:0] functs [7];
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25;
        functs[4] = 6'h2A; functs[5] = 6'h18; functs[6] = 6'h3F;

        // Reset state
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // R-type add 5 + 7
        clear_inputs();
        ALUop = 2'b10; offsetIn = 32'h20; register1In = 32'd5; register2In = 32'd7;
        RegDst = 1'b1; registerDestinationIn = 5'd9; pcIn = 7'd3;
        exec("add");

        // Subtract to zero and branch target wrap
        clear_inputs();
        ALUop = 2'b01; register1In = 32'h1234; register2In = 32'h1234;
        pcIn = 7'h7E; offsetIn = 32'd4;
        exec("sub_zero");
        check("btgt_wrap", {25'd0, branchTargetOut}, 32'h02);
        check("zero_flag", {31'd0, zeroOut}, 32'd1);

        // Forwarding priority: both stages hit rs=3, MEM wins
        clear_inputs();
        offsetIn = 32'd3 << 21; register1In = 32'd1;
        memRegWrite = 1'b1; memRd = 5'd3; memData = 32'd9;
        wbRegWrite = 1'b1; wbRd = 5'd3; wbData = 32'd4;
        exec("fwd_mem");
        check("fwd_mem_A", aluResultOut, 32'd9);
        memRegWrite = 1'b0;
        exec("fwd_wb");
        check("fwd_wb_A", aluResultOut, 32'd4);
        offsetIn = 32'd0; memRegWrite = 1'b1; memRd = 5'd0; wbRd = 5'd0;
        exec("fwd_r0");
        check("fwd_r0_A", aluResultOut, 32'd1);

        // Multiply -3 * 7, with forwarding source changing mid-multiply
        clear_inputs();
        ALUop = 2'b10; offsetIn = (32'd5 << 21) | 32'h18; writeBackIn = 2'b11; memoryIn = 3'b101;
        register1In = 32'd77; register2In = 32'd7; registerTargetIn = 5'd6;
        memRegWrite = 1'b1; memRd = 5'd5; memData = -32'sd3;
        fork
            exec("mult");
            begin
                repeat (10) @(posedge clock);
                #2;
                memData = 32'd100;
            end
        join
        check("mult_product", aluResultOut, 32'hFFFFFFEB);

        // Back-to-back multiplies
        clear_inputs();
        ALUop = 2'b10; offsetIn = 32'h18; register1In = 32'h12345; register2In = -32'sd9;
        exec("mult_b2b_1");
        register1In = 32'hFFFF0001; register2In = 32'h10001;
        exec("mult_b2b_2");

        // Reset in the middle of a multiply, then an add completes in one cycle
        clear_inputs();
        ALUop = 2'b10; offsetIn = 32'h18; register1In = -32'sd3; register2In = 32'd7; pcIn = 7'h11;
        #1;
        repeat (11) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clock);
        #1;
        clear_inputs();
        ALUop = 2'b10; offsetIn = 32'h20; register1In = 32'd40; register2In = 32'd2;
        reset_n = 1'b1;
        exec("post_reset_add");
        check("post_reset_val", aluResultOut, 32'd42);

        // Randomized instructions
        for (int i = 0; i < 60; i++) begin
            writeBackIn = 2'($urandom); memoryIn = 3'($urandom);
            ALUop = 2'($urandom); ALUSrc = 1'($urandom); RegDst = 1'($urandom);
            pcIn = 7'($urandom); register1In = $urandom; register2In = $urandom;
            offsetIn = $urandom;
            offsetIn[25:21] = 5'($urandom_range(0, 3));
            if (ALUop == 2'b10) offsetIn[5:0] = functs[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) register2In = register1In;
            registerTargetIn = 5'($urandom_range(0, 3)); registerDestinationIn = 5'($urandom);
            memRegWrite = 1'($urandom); memRd = 5'($urandom_range(0, 3)); memData = $urandom;
            wbRegWrite = 1'($urandom); wbRd = 5'($urandom_range(0, 3)); wbData = $urandom;
            exec("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs from the ID/EX register: writeBackIn[1:0], memoryIn[2:0], ALUop[1:0], ALUSrc, RegDst, pcIn[6:0], register1In[31:0], register2In[31:0], offsetIn[31:0], registerTargetIn[4:0], registerDestinationIn[4:0].
REQ-004 SHALL have forwarding inputs: memRegWrite (1), memRd[4:0], memData[31:0] (EX/MEM stage); wbRegWrite (1), wbRd[4:0], wbData[31:0] (MEM/WB stage).
REQ-005 SHALL have registered outputs forming the EX/MEM register: writeBackOut[1:0], memoryOut[2:0], aluResultOut[31:0], writeDataOut[31:0], registerDestOut[4:0], zeroOut (1), branchTargetOut[6:0].
REQ-006 SHALL have output stallOut (1): ID/EX and earlier stages hold while high.

Function
REQ-007 Operand A SHALL be memData if memRegWrite and memRd!=0 and memRd==rs; otherwise wbData if wbRegWrite and wbRd!=0 and wbRd==rs; otherwise register1In. rs is offsetIn[25:21].
REQ-008 Forwarded B SHALL use the same priority against rt=registerTargetIn. The ALU B input SHALL be offsetIn when ALUSrc=1, else forwarded B.
REQ-009 ALU operation by ALUop:
  - 00: add
  - 01: sub
  - 11: add
  - 10: by funct=offsetIn[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, 0x18 mult.
  - Any other funct: add.
REQ-010 Arithmetic SHALL be 32-bit wrap-around with no overflow trap. Mult result SHALL be the low 32 bits of the signed product.
REQ-011 zeroOut SHALL be 1 iff the 32-bit ALU result equals 0.
REQ-012 branchTargetOut SHALL equal pcIn + offsetIn[6:0], truncated to 7 bits (wraps).
REQ-013 registerDestOut SHALL be registerDestinationIn when RegDst=1, else registerTargetIn.
REQ-014 writeDataOut SHALL be forwarded B.
REQ-015 Non-mult ops: EX/MEM outputs SHALL load on the next rising edge (latency 1), stallOut=0.
REQ-016 Multiply FSM states SHALL be IDLE and MUL, using a 5-bit iteration counter and a shift-add datapath.
REQ-017 IDLE + mult presented: stallOut=1 (combinational); next edge captures forwarded A/B, cnt<=0, state<=MUL.
REQ-018 MUL with cnt<31: stallOut=1, one product bit per edge, cnt++.
REQ-019 MUL with cnt==31: stallOut=0; next edge loads the final product into aluResultOut with the mult's control fields and returns to IDLE.
REQ-020 stallOut SHALL be high for exactly 32 consecutive cycles per mult; the product SHALL appear on the 33rd edge after the mult is presented.
REQ-021 On every edge while stallOut=1, EX/MEM SHALL load a bubble: writeBackOut=0, memoryOut=0, other fields don't-care.
REQ-022 Operands captured at mult start SHALL be unaffected by later forwarding-input changes.
REQ-023 Back-to-back mults SHALL each take the full 32-cycle stall. The second starts from IDLE the cycle after the first completes.

Reset
REQ-024 reset_n low SHALL immediately clear all outputs to 0, state to IDLE, cnt to 0 and the multiplier registers to 0.
REQ-025 Reset mid-multiply SHALL abort with no product emitted. stallOut SHALL be 0 while reset_n is low.

Structure
REQ-026 A shared package SHALL hold ALUop encodings, funct constants (ADD/SUB/AND/OR/SLT/MULT), FSM state type and MULT_CYCLES=32.
REQ-027 The iterative multiplier SHALL be one sub-module, seq_multiplier (start, a, b -> busy, last, product). Forwarding, ALU and EX/MEM register SHALL stay in ex_stage.

Verification
REQ-028 ALUop=10, funct=0x20, A=5, B=7 -> aluResultOut=12, zeroOut=0 after 1 edge; stallOut never high.
REQ-029 ALUop=01, A=B=0x1234 -> zeroOut=1. pcIn=0x7E, offsetIn=4 -> branchTargetOut=0x02.
REQ-030 memRd=wbRd=rs=3, both RegWrite, memData=9, wbData=4, register1In=1 -> A=9. Same with rs=0 -> A=register1In.
REQ-031 mult A=-3, B=7 -> stallOut high 32 cycles, 32 bubbles with writeBackOut=0, then aluResultOut=0xFFFFFFEB.
REQ-032 reset_n low at iteration 10 of a mult -> outputs 0 and stallOut=0 immediately. After release, a new add completes in 1 cycle.
